adc_serial_sampler: RTL and testbench
=====================================

// Module: adc_serial_sampler
// PURPOSE
//  Parametrised serial-ADC capture engine for the LocTag detector path.
//  Drives CS_n/SCLK of an AD7476-class ADC, shifts in MSB-first frames, and
//  presents samples on a valid/ready port with an overrun flag and a
//  threshold compare. Supports off, continuous, single-shot and
//  trigger-started modes. Sits between the ADC pins and the detector logic.
// PARAMETERS
//  DATA_W     12  sample bits kept per frame
//  LEAD_BITS   4  leading bits clocked and discarded before the MSB
//  CLK_DIV     4  SCLK half-period in clk cycles (>=1)
//  QUIET_CYC   2  CS_n-high cycles between frames (>=1)
//  AVG_LOG2    2  log2 of the averaging count (used only with ADC_AVG_EN)
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous active-low reset
//  mode         in   2       00 off, 01 continuous, 10 single, 11 triggered
//  start        in   1       single-shot request pulse (mode 10)
//  trig_in      in   1       asynchronous trigger; rising edge starts a frame (mode 11)
//  adc_cs_n     out  1       ADC chip select, active low
//  adc_sclk     out  1       ADC serial clock; idles high
//  adc_so       in   1       ADC serial data
//  sample       out  DATA_W  captured (or averaged) sample
//  sample_valid out  1       sample holds unread data
//  sample_ready in   1       consumer accepts sample this cycle
//  threshold    in   DATA_W  compare level
//  above        out  1       registered (sample >= threshold) at load time
//  overrun      out  1       sticky: a sample was dropped
//  clr_overrun  in   1       clears overrun
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset: adc_cs_n=1, adc_sclk=1, sample=0, sample_valid=0, above=0,
//   overrun=0, busy=0, state=IDLE, counters=0, 2-FF trig synchroniser=0.
//  FSM: IDLE -> SETUP -> SHIFT -> QUIET -> IDLE, or QUIET -> SETUP in mode 01.
//   IDLE: mode 01 -> SETUP; mode 10 with start=1 -> SETUP;
//    mode 11 with synchronised trig rising edge -> SETUP.
//   SETUP: CS_n=0, SCLK=1 for CLK_DIV cycles.
//   SHIFT: FRAME_W = LEAD_BITS+DATA_W bits. Per bit: SCLK=0 for CLK_DIV
//    cycles, then SCLK=1 for CLK_DIV cycles. adc_so is sampled on the clk
//    edge that raises SCLK. The first LEAD_BITS bits are discarded; the
//    rest shift into the register MSB first.
//   QUIET: CS_n=1, SCLK=1 for QUIET_CYC cycles. Then mode 01 -> SETUP,
//    else IDLE.
//  Frame period = CLK_DIV + 2*CLK_DIV*FRAME_W + QUIET_CYC cycles.
//  Completion: the conversion result is ready on the first QUIET cycle.
//  Output buffer (1 entry):
//   - If !sample_valid, or sample_ready is high that cycle: load sample,
//     set sample_valid=1, update above.
//   - Else: drop the new result and set overrun=1.
//   - sample_ready with nothing arriving clears sample_valid.
//   - clr_overrun and a same-cycle overrun event: set wins.
//  start or trig edges while busy are ignored; they are not queued.
//  mode->00 during SETUP/SHIFT: abort on the next cycle. Go to QUIET with
//   CS_n=1 and SCLK=1, discard the partial frame, clear the accumulator,
//   and load no sample. Mode changes between 01/10/11 take effect at the
//   next IDLE/QUIET decision.
//  Counters wrap only by design limits (bit and cycle counters reload per
//   phase); no output pulse on the SCLK pin is shorter than CLK_DIV cycles.
// CONFIGURATION
//  ADC_AVG_EN defined:
//   - Frames accumulate into a DATA_W+AVG_LOG2 bit sum.
//   - After 2**AVG_LOG2 frames, the result is sum>>AVG_LOG2 (truncated)
//     and the sum clears. Overrun and threshold rules apply to this result.
//   - In mode 10, one start runs 2**AVG_LOG2 back-to-back frames.
//   - In mode 11, one trigger edge does the same.
//  ADC_AVG_EN undefined: every frame is a result; no accumulator logic.
// TESTING (DATA_W=12, LEAD_BITS=4, CLK_DIV=2, QUIET_CYC=2 -> 68-cycle frame)
//  1. mode=01, ADC model returns 0xA5C:
//     -> sample_valid every 68 cycles, sample=0xA5C; SCLK high/low 2 cycles
//        each; 16 falling edges per CS_n-low window.
//  2. mode=10, start pulse, ADC=0x001, threshold=0x001:
//     -> one frame only, sample=0x001, above=1. A second start during
//        busy is ignored.
//  3. mode=01, sample_ready=0 for 3 frames:
//     -> first sample kept, overrun=1. Then clr_overrun -> overrun=0.
//        Ready on the completion cycle -> new sample, no overrun.
//  4. mode=11, trig_in rising edge:
//     -> CS_n falls 3-4 cycles later; a trig held high starts no more frames.
//  5. mode->00 at bit 7 of SHIFT, and reset_n low mid-SHIFT:
//     -> CS_n=1 and SCLK=1 within 1 cycle (abort) or immediately (reset);
//        no sample_valid.
//  6. ADC_AVG_EN, AVG_LOG2=2, frames 100,101,102,104:
//     -> one sample=101 after the 4th frame.

Source files
------------

// File: rtl/adc_serial_sampler.sv
// adc_serial_sampler: serial-ADC capture engine for an AD7476-class converter.
// Drives CS_n/SCLK, shifts in MSB-first frames, and presents each result on a
// one-entry valid/ready buffer with a sticky overrun flag and a threshold
// compare. Modes: off, continuous, single-shot and trigger-started.
// Optional build macro ADC_AVG_EN: average 2**AVG_LOG2 frames per result.
module adc_serial_sampler #(
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 4,
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 2,
    parameter int AVG_LOG2  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              trig_in,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    input  logic              adc_so,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    input  logic [DATA_W-1:0] threshold,
    output logic              above,
    output logic              overrun,
    input  logic              clr_overrun,
    output logic              busy
);

    localparam int FRAME_W = LEAD_BITS + DATA_W;
    localparam int CNT_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_TRIG   = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sclk_high;      // second half of the current bit
    logic               sclk_low_next;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  result;
    logic               frame_end;      // last bit finished normally
    logic               abort;          // mode went off mid-frame
    logic               frame_done;     // result is valid this cycle
    logic               more_frames;
    logic               div_end;
    logic               trig_meta, trig_sync, trig_prev, trig_rise;

    assign div_end   = (cyc_cnt == DIV_LAST);
    assign trig_rise = trig_sync & ~trig_prev;
    assign busy      = (state != IDLE);

    // Next-state decode, abort/completion strobes and next SCLK level
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next = state;
        frame_end  = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (mode == MODE_CONT ||
                    (mode == MODE_SINGLE && start) ||
                    (mode == MODE_TRIG && trig_rise))
                    state_next = SETUP;
            end
            SETUP: begin
                if (mode == MODE_OFF) begin
                    state_next = QUIET;
                    abort      = 1'b1;
                end else if (div_end) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (mode == MODE_OFF) begin
                    state_next = QUIET;
                    abort      = 1'b1;
                end else if (div_end && sclk_high && bit_cnt == BIT_LAST) begin
                    state_next = QUIET;
                    frame_end  = 1'b1;
                end
            end
            QUIET: begin
                if (cyc_cnt == QUIET_LAST)
                    state_next = (mode == MODE_CONT || more_frames) ? SETUP : IDLE;
            end
            default: state_next = IDLE;
        endcase

        // SCLK is low in the first half of each bit; entering SHIFT starts low.
        if (state_next != SHIFT)
            sclk_low_next = 1'b0;
        else if (state != SHIFT)
            sclk_low_next = 1'b1;
        else
            sclk_low_next = div_end ? sclk_high : ~sclk_high;
    end

    // State register and registered pin drivers (glitch-free CS_n/SCLK)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state    <= state_next;
            adc_cs_n <= ~(state_next == SETUP || state_next == SHIFT);
            adc_sclk <= ~sclk_low_next;
        end
    end

    // Phase counters; they reload on every state change and every half-bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            sclk_high <= 1'b0;
        end else if (state_next != state) begin
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            sclk_high <= 1'b0;
        end else if (state == SHIFT) begin
            if (div_end) begin
                cyc_cnt   <= '0;
                sclk_high <= ~sclk_high;
                if (sclk_high)
                    bit_cnt <= bit_cnt + BIT_W'(1);
            end else begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
        end else if (state == SETUP || state == QUIET) begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
    end

    // Shift adc_so in on the edge that raises SCLK; lead bits fall off the top
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            shift_reg <= '0;
        else if (state == SHIFT && !sclk_high && div_end && mode != MODE_OFF)
            shift_reg <= {shift_reg[DATA_W-2:0], adc_so};
    end

    // Two-flop trigger synchroniser plus edge-detect history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_meta <= 1'b0;
            trig_sync <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_meta <= trig_in;
            trig_sync <= trig_meta;
            trig_prev <= trig_sync;
        end
    end

`ifdef ADC_AVG_EN
    localparam int SUM_W = DATA_W + AVG_LOG2;

    logic [SUM_W-1:0]    acc;
    logic [SUM_W-1:0]    frame_sum;
    logic [AVG_LOG2-1:0] avg_cnt;
    logic [DATA_W-1:0]   result_q;

    assign frame_sum   = acc + SUM_W'(shift_reg);
    assign more_frames = (mode != MODE_OFF) && (avg_cnt != '0);
    assign result      = result_q;

    // Accumulate frames; emit the truncated mean when the group completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            avg_cnt    <= '0;
            result_q   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (abort || (state == QUIET && state_next == IDLE && !frame_done)) begin
                acc     <= '0;
                avg_cnt <= '0;
            end else if (frame_end) begin
                avg_cnt <= avg_cnt + AVG_LOG2'(1);
                if (&avg_cnt) begin
                    result_q   <= frame_sum[SUM_W-1:AVG_LOG2];
                    acc        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    acc <= frame_sum;
                end
            end
        end
    end
`else
    assign more_frames = 1'b0;
    assign result      = shift_reg;

    // Every completed frame is a result, ready on the first QUIET cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            frame_done <= 1'b0;
        else
            frame_done <= frame_end;
    end
`endif

    // One-entry output buffer with threshold compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            above        <= 1'b0;
        end else if (frame_done) begin
            if (!sample_valid || sample_ready) begin
                sample       <= result;
                sample_valid <= 1'b1;
                above        <= (result >= threshold);
            end
        end else if (sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    // Sticky overrun: a dropped result beats a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overrun <= 1'b0;
        else if (frame_done && sample_valid && !sample_ready)
            overrun <= 1'b1;
        else if (clr_overrun)
            overrun <= 1'b0;
    end

endmodule

// File: tb/tb_adc_serial_sampler.sv
// Directed self-checking bench for adc_serial_sampler with a behavioural
// AD7476-style ADC model (CLK_DIV=2, QUIET_CYC=2 -> 68-cycle frame).
module tb_adc_serial_sampler;

    localparam int DATA_W    = 12;
    localparam int FRAME_CYC = 68;
`ifdef ADC_AVG_EN
    localparam int AVG_N = 4;
`else
    localparam int AVG_N = 1;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        mode;
    logic              start;
    logic              trig_in;
    logic              adc_cs_n;
    logic              adc_sclk;
    logic              adc_so = 1'b0;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;
    logic [DATA_W-1:0] threshold;
    logic              above;
    logic              overrun;
    logic              clr_overrun;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_serial_sampler #(
        .DATA_W(12), .LEAD_BITS(4), .CLK_DIV(2), .QUIET_CYC(2), .AVG_LOG2(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .start(start),
        .trig_in(trig_in), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
        .adc_so(adc_so), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .threshold(threshold), .above(above),
        .overrun(overrun), .clr_overrun(clr_overrun), .busy(busy)
    );

    // ADC model: new frame word on CS_n fall, next bit after each SCLK fall
    logic [11:0] adc_vals [4];
    logic [15:0] adc_word  = '0;
    int          frame_idx = 0;
    int          frame_base = 0;
    int          fall_cnt  = 0;
    int          cs_falls  = 0;
    int          last_falls = 0;

    always @(negedge adc_cs_n or negedge adc_sclk) begin
        if (adc_sclk === 1'b0) begin
            if (adc_cs_n === 1'b0) begin
                if (fall_cnt < 16) adc_so = adc_word[15 - fall_cnt];
                fall_cnt++;
            end
        end else begin
            adc_word = {4'h0, adc_vals[(frame_idx - frame_base) % 4]};
            frame_idx++;
            fall_cnt = 0;
            cs_falls++;
        end
    end

    always @(posedge adc_cs_n) last_falls = fall_cnt;

    // SCLK level run lengths (in clk cycles) while CS_n is low
    logic last_lvl = 1'b1;
    logic in_win   = 1'b0;
    int   run = 0, run_min = 999, run_max = 0;

    always @(negedge clk) begin
        if (adc_cs_n === 1'b0) begin
            if (in_win && adc_sclk == last_lvl) begin
                run++;
            end else begin
                if (in_win) begin
                    if (run < run_min) run_min = run;
                    if (run > run_max) run_max = run;
                end
                run = 1;
                last_lvl = adc_sclk;
                in_win = 1'b1;
            end
        end else begin
            if (in_win) begin
                if (run < run_min) run_min = run;
                if (run > run_max) run_max = run;
            end
            in_win = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (sample_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_bit(input int bits, input int budget);
        int n = 0;
        while (!(adc_cs_n === 1'b0 && fall_cnt == bits) && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic set_vals(input logic [11:0] v0, v1, v2, v3);
        frame_base  = frame_idx;
        adc_vals[0] = v0;
        adc_vals[1] = v1;
        adc_vals[2] = v2;
        adc_vals[3] = v3;
    endtask

    initial begin
        int t1, t2, c, n, n_valid;

        reset_n = 1'b0; mode = 2'b00; start = 1'b0; trig_in = 1'b0;
        sample_ready = 1'b0; threshold = '0; clr_overrun = 1'b0;
        set_vals(12'h0, 12'h0, 12'h0, 12'h0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_above", above, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Continuous capture of 0xA5C
        set_vals(12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C);
        threshold = 12'hFFF; sample_ready = 1'b1; mode = 2'b01;
        wait_valid(400);
        check("cont_valid1", sample_valid, 1);
        t1 = cyc;
        check("cont_sample1", sample, 12'hA5C);
        check("cont_above", above, 0);
        @(negedge clk);
        check("cont_ready_clears", sample_valid, 0);
        wait_valid(400);
        t2 = cyc;
        check("cont_period", t2 - t1, FRAME_CYC * AVG_N);
        check("cont_sample2", sample, 12'hA5C);
        check("sclk_run_min", run_min, 2);
        check("sclk_run_max", run_max, 2);
        check("sclk_falls", last_falls, 16);
        mode = 2'b00;
        wait_idle(200);
        check("cont_stop_idle", busy, 0);

        // Single shot at the threshold; a second start while busy is ignored
        set_vals(12'h001, 12'h001, 12'h001, 12'h001);
        threshold = 12'h001; c = cs_falls; mode = 2'b10;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_valid(400);
        check("single_valid", sample_valid, 1);
        check("single_sample", sample, 12'h001);
        check("single_above", above, 1);
        repeat (150) @(negedge clk);
        check("single_frames", cs_falls - c, AVG_N);
        check("single_idle", busy, 0);
        mode = 2'b00;

`ifndef ADC_AVG_EN
        // Overrun with a stalled consumer, clear, then ready on completion
        sample_ready = 1'b0;
        set_vals(12'h111, 12'h222, 12'h333, 12'h444);
        mode = 2'b01;
        wait_valid(200);
        t1 = cyc;
        check("ovr_first", sample, 12'h111);
        repeat (141) @(negedge clk);
        check("ovr_kept", sample, 12'h111);
        check("ovr_valid", sample_valid, 1);
        check("ovr_set", overrun, 1);
        clr_overrun = 1'b1; @(negedge clk); clr_overrun = 1'b0;
        check("ovr_clr", overrun, 0);
        repeat ((t1 + 203) - cyc) @(negedge clk);
        sample_ready = 1'b1; @(negedge clk); sample_ready = 1'b0;
        check("ovr_new_sample", sample, 12'h444);
        check("ovr_new_valid", sample_valid, 1);
        check("ovr_none", overrun, 0);
        mode = 2'b00; sample_ready = 1'b1;
        wait_idle(200);
`endif

        // Triggered start; trigger held high starts nothing more
        sample_ready = 1'b1;
        set_vals(12'h3C3, 12'h3C3, 12'h3C3, 12'h3C3);
        mode = 2'b11;
        repeat (2) @(negedge clk);
        c = cs_falls; t1 = cyc;
        trig_in = 1'b1;
        n = 0;
        while (adc_cs_n !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("trig_latency", ((cyc - t1) >= 3 && (cyc - t1) <= 4), 1);
        wait_valid(400);
        check("trig_sample", sample, 12'h3C3);
        repeat (150) @(negedge clk);
        check("trig_held_frames", cs_falls - c, AVG_N);
        trig_in = 1'b0; mode = 2'b00;
        wait_idle(200);

        // Abort at bit 7 of SHIFT
        sample_ready = 1'b1; @(negedge clk); sample_ready = 1'b0;
        set_vals(12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5);
        mode = 2'b01;
        wait_bit(8, 200);
        mode = 2'b00;
        @(negedge clk);
        check("abort_cs_n", adc_cs_n, 1);
        check("abort_sclk", adc_sclk, 1);
        n_valid = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) n_valid++;
        end
        check("abort_no_valid", n_valid, 0);
        check("abort_idle", busy, 0);

        // Reset mid-SHIFT
        mode = 2'b01;
        wait_bit(5, 200);
        check("rst_mid_in_frame", adc_cs_n, 0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_cs_n", adc_cs_n, 1);
        check("rst_mid_sclk", adc_sclk, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", sample_valid, 0);
        mode = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef ADC_AVG_EN
        // Four-frame average from one start
        set_vals(12'd100, 12'd101, 12'd102, 12'd104);
        threshold = 12'd0; sample_ready = 1'b1; c = cs_falls;
        mode = 2'b10;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_valid(600);
        check("avg_sample", sample, 12'd101);
        check("avg_frames", cs_falls - c, 4);
        mode = 2'b00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
